jtag_ir_dr: RTL and testbench
=============================

JTAG_IR_DR -- requirements
Module: jtag_ir_dr

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 5, instruction register width (min 2).
REQ-002 SHALL have parameter IDCODE_VAL, default 32'h1000_0001, IDCODE capture value; bit 0 fixed 1.
REQ-003 SHALL have parameter OP_IDCODE, default 5'b00001, IDCODE opcode.
REQ-004 SHALL have parameter OP_USER, default 5'b01000, user data register opcode.
REQ-005 SHALL have parameter OP_BYPASS, default 5'b11111, bypass opcode.
REQ-006 Ports (name direction width meaning):
- TCK input 1: the single clock; all state changes on its rising edge.
- TRST input 1: reset, synchronous and active-high.
- test_reset input 1: TAP in Test-Logic-Reset.
- ir_capture / ir_shift / ir_update inputs 1 each: TAP IR strobes.
- dr_capture / dr_shift / dr_update inputs 1 each: TAP DR strobes.
- TDI input 1: serial data in.
- TDO output 1: serial data out.
- tdo_en output 1: TDO valid / drive enable.
- instr output IR_WIDTH: active instruction.
- user_capture / user_shift / user_update outputs 1 each: gated DR strobes for external user chain.
- user_tdo input 1: serial out of external user chain.

Function
REQ-007 SHALL hold ir_sr (IR_WIDTH shift register), instr (update register), bypass_sr (1 bit), id_sr (32 bits).
REQ-008 ir_capture SHALL load ir_sr with IR_WIDTH'b0...01 (LSBs "01" per IEEE 1149.1).
REQ-009 ir_shift SHALL shift ir_sr right: ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]}; LSB leaves first.
REQ-010 ir_update SHALL copy ir_sr to instr; ir_sr unchanged.
REQ-011 Decode SHALL be: instr==OP_IDCODE -> IDCODE DR; instr==OP_USER -> user DR; any other value, including OP_BYPASS and undefined opcodes -> BYPASS DR.
REQ-012 dr_capture with IDCODE selected SHALL load id_sr with IDCODE_VAL; with BYPASS selected SHALL clear bypass_sr to 0.
REQ-013 dr_shift SHALL shift only the selected register: id_sr <= {TDI, id_sr[31:1]}; bypass_sr <= TDI.
REQ-014 dr_update SHALL have no internal effect for IDCODE or BYPASS.
REQ-015 user_capture/user_shift/user_update SHALL equal dr_capture/dr_shift/dr_update ANDed with (instr==OP_USER), combinationally, and SHALL be 0 otherwise.
REQ-016 TDO SHALL be combinational: ir_shift -> ir_sr[0]; else dr_shift -> id_sr[0], bypass_sr, or user_tdo per selection; else 0.
REQ-017 tdo_en SHALL equal ir_shift | dr_shift.
REQ-018 Within the IR group, priority SHALL be capture > shift > update when strobes overlap; the DR group follows the same rule independently.
REQ-019 test_reset SHALL set instr to OP_IDCODE on the next edge, overriding ir_update; ir_sr, id_sr and bypass_sr SHALL be unaffected.
REQ-020 Latency: capture/shift/update effects SHALL be visible one TCK edge after the strobe; TDO SHALL reflect the new LSB in the same cycle as the register change.
REQ-021 BYPASS path SHALL add exactly one TCK of delay from TDI to TDO.

Reset
REQ-022 TRST high at a rising TCK edge SHALL set instr=OP_IDCODE, ir_sr=IR_WIDTH'b0...01, id_sr=IDCODE_VAL, bypass_sr=0; TRST overrides all strobes.
REQ-023 During and after reset with no strobes active, TDO=0, tdo_en=0, and user_* = 0.
REQ-024 TRST asserted mid-shift SHALL abort the shift; the next capture SHALL restart cleanly.

Verification
REQ-025 Reset, then dr_capture for 1 cycle and dr_shift for 32 cycles with TDI=0 -> TDO LSB-first = 32'h1000_0001; tdo_en=1 throughout the shift.
REQ-026 ir_capture, then 5 ir_shift cycles with TDI bits 1,1,1,1,1 -> TDO = 1,0,0,0,0; ir_update -> instr=5'b11111.
REQ-027 BYPASS selected, dr_capture, then dr_shift with TDI pattern 1,0,1,1 -> TDO = 0,1,0,1 (one-cycle delay, leading 0).
REQ-028 Load undefined opcode 5'b00110 -> DR path behaves as BYPASS; user_* stay 0.
REQ-029 instr=OP_USER, user_tdo toggling, dr_shift=1 -> user_shift=1 and TDO=user_tdo each cycle; test_reset=1 for 1 cycle -> instr=5'b00001 and user_shift=0.
REQ-030 TRST=1 during the 10th IDCODE shift cycle -> next edge id_sr=IDCODE_VAL, instr=OP_IDCODE, TDO=0.

Source files
------------

// File: rtl/jtag_ir_dr.sv
// JTAG instruction register and data-register mux.
// It holds the IR, IDCODE and BYPASS chains and gates DR strobes out to an external user chain.
module jtag_ir_dr #(
    parameter int unsigned            IR_WIDTH   = 5,
    parameter logic [31:0]            IDCODE_VAL = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0]    OP_IDCODE  = IR_WIDTH'(5'b00001),
    parameter logic [IR_WIDTH-1:0]    OP_USER    = IR_WIDTH'(5'b01000),
    parameter logic [IR_WIDTH-1:0]    OP_BYPASS  = IR_WIDTH'(5'b11111)
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                test_reset,
    input  logic                ir_capture,
    input  logic                ir_shift,
    input  logic                ir_update,
    input  logic                dr_capture,
    input  logic                dr_shift,
    input  logic                dr_update,
    input  logic                TDI,
    output logic                TDO,
    output logic                tdo_en,
    output logic [IR_WIDTH-1:0] instr,
    output logic                user_capture,
    output logic                user_shift,
    output logic                user_update,
    input  logic                user_tdo
);

    localparam int unsigned ID_WIDTH = 32;

    // IEEE 1149.1 requires the IR capture pattern to end in "01".
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);
    localparam logic [ID_WIDTH-1:0] ID_LOAD    = {IDCODE_VAL[ID_WIDTH-1:1], 1'b1};

    logic [IR_WIDTH-1:0] ir_sr;
    logic [ID_WIDTH-1:0] id_sr;
    logic                bypass_sr;
    logic                sel_id;
    logic                sel_user;

    // Every opcode that is neither IDCODE nor USER falls through to BYPASS, OP_BYPASS included.
    assign sel_id   = (instr == OP_IDCODE);
    assign sel_user = (instr == OP_USER);

    // Instruction path: capture > shift > update; test_reset forces IDCODE.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            ir_sr <= IR_CAPTURE;
            instr <= OP_IDCODE;
        end else begin
            if (ir_capture) begin
                ir_sr <= IR_CAPTURE;
            end else if (ir_shift) begin
                ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};
            end

            if (test_reset) begin
                instr <= OP_IDCODE;
            end else if (ir_update && !ir_capture && !ir_shift) begin
                instr <= ir_sr;
            end
        end
    end

    // Data path: only the selected internal register moves; update has no internal effect.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            id_sr     <= ID_LOAD;
            bypass_sr <= 1'b0;
        end else if (dr_capture) begin
            if (sel_id) begin
                id_sr <= ID_LOAD;
            end else if (!sel_user) begin
                bypass_sr <= 1'b0;
            end
        end else if (dr_shift) begin
            if (sel_id) begin
                id_sr <= {TDI, id_sr[ID_WIDTH-1:1]};
            end else if (!sel_user) begin
                bypass_sr <= TDI;
            end
        end
    end

    assign user_capture = dr_capture & sel_user;
    assign user_shift   = dr_shift & sel_user;
    assign user_update  = dr_update & sel_user;
    assign tdo_en       = ir_shift | dr_shift;

    // Serial output mux; TDO is low whenever nothing is shifting.
    always_comb begin
        TDO = 1'b0;
        if (ir_shift) begin
            TDO = ir_sr[0];
        end else if (dr_shift) begin
            if (sel_id) begin
                TDO = id_sr[0];
            end else if (sel_user) begin
                TDO = user_tdo;
            end else begin
                TDO = bypass_sr;
            end
        end
    end

endmodule

// File: tb/tb_jtag_ir_dr.sv
// Directed testbench for jtag_ir_dr.
// Inputs change just after the falling edge and outputs are sampled 1 ns later.
module tb_jtag_ir_dr;

    logic       TCK = 1'b0;
    logic       TRST, test_reset;
    logic       ir_capture, ir_shift, ir_update;
    logic       dr_capture, dr_shift, dr_update;
    logic       TDI, TDO, tdo_en;
    logic [4:0] instr;
    logic       user_capture, user_shift, user_update, user_tdo;

    int checks = 0;
    int errors = 0;

    logic [31:0] tdo_bits;
    logic [31:0] us_bits;
    logic [4:0]  ir_bits;

    always #5 TCK = ~TCK;

    jtag_ir_dr dut (
        .TCK          (TCK),
        .TRST         (TRST),
        .test_reset   (test_reset),
        .ir_capture   (ir_capture),
        .ir_shift     (ir_shift),
        .ir_update    (ir_update),
        .dr_capture   (dr_capture),
        .dr_shift     (dr_shift),
        .dr_update    (dr_update),
        .TDI          (TDI),
        .TDO          (TDO),
        .tdo_en       (tdo_en),
        .instr        (instr),
        .user_capture (user_capture),
        .user_shift   (user_shift),
        .user_update  (user_update),
        .user_tdo     (user_tdo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        test_reset = 1'b0;
        ir_capture = 1'b0;
        ir_shift   = 1'b0;
        ir_update  = 1'b0;
        dr_capture = 1'b0;
        dr_shift   = 1'b0;
        dr_update  = 1'b0;
        TDI        = 1'b0;
    endtask

    // Shift n DR bits; collects TDO and user_shift per cycle and checks tdo_en.
    task automatic shift_dr(input int n, input logic [31:0] tdi_v,
                            output logic [31:0] tdo_v, output logic [31:0] us_v);
        tdo_v = '0;
        us_v  = '0;
        for (int i = 0; i < n; i++) begin
            dr_shift = 1'b1;
            TDI      = tdi_v[i];
            #1;
            tdo_v[i] = TDO;
            us_v[i]  = user_shift;
            if (tdo_en !== 1'b1) chk("dr_shift_tdo_en", 32'(tdo_en), 32'd1);
            @(negedge TCK);
        end
        idle();
    endtask

    // Capture, shift in op LSB-first, update; returns the bits seen on TDO.
    task automatic load_ir(input logic [4:0] op, output logic [4:0] tdo_v);
        tdo_v = '0;
        ir_capture = 1'b1;
        #1;
        @(negedge TCK);
        ir_capture = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ir_shift = 1'b1;
            TDI      = op[i];
            #1;
            tdo_v[i] = TDO;
            @(negedge TCK);
        end
        idle();
        ir_update = 1'b1;
        #1;
        @(negedge TCK);
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        user_tdo = 1'b0;
        TRST     = 1'b1;
        @(negedge TCK);
        @(negedge TCK);
        #1;
        chk("rst_tdo", 32'(TDO), 32'd0);
        chk("rst_tdo_en", 32'(tdo_en), 32'd0);
        chk("rst_user", 32'({user_capture, user_shift, user_update}), 32'd0);
        chk("rst_instr", 32'(instr), 32'h01);

        // IDCODE readout after reset
        TRST       = 1'b0;
        dr_capture = 1'b1;
        #1;
        chk("id_cap_user", 32'(user_capture), 32'd0);
        @(negedge TCK);
        idle();
        shift_dr(32, 32'h0, tdo_bits, us_bits);
        chk("idcode_out", tdo_bits, 32'h1000_0001);
        #1;
        chk("idle_tdo_en", 32'(tdo_en), 32'd0);

        // IR load of BYPASS, observing the captured "01" pattern
        load_ir(5'b11111, ir_bits);
        chk("ir_capture_out", 32'(ir_bits), 32'h01);
        #1;
        chk("instr_bypass", 32'(instr), 32'h1f);

        // BYPASS: one-cycle delay with a leading 0
        dr_capture = 1'b1;
        #1;
        @(negedge TCK);
        idle();
        shift_dr(4, 32'b1101, tdo_bits, us_bits);
        chk("bypass_out", tdo_bits, 32'b1010);

        // IR priority: capture beats shift, then shift beats update
        ir_capture = 1'b1;
        ir_shift   = 1'b1;
        TDI        = 1'b1;
        #1;
        @(negedge TCK);
        idle();
        ir_shift  = 1'b1;
        ir_update = 1'b1;
        #1;
        chk("ir_prio_capture", 32'(TDO), 32'd1);
        @(negedge TCK);
        idle();
        #1;
        chk("ir_prio_update", 32'(instr), 32'h1f);

        // Undefined opcode decodes to BYPASS
        load_ir(5'b00110, ir_bits);
        #1;
        chk("instr_undef", 32'(instr), 32'h06);
        dr_capture = 1'b1;
        #1;
        chk("undef_user_cap", 32'(user_capture), 32'd0);
        @(negedge TCK);
        idle();
        shift_dr(3, 32'b011, tdo_bits, us_bits);
        chk("undef_bypass_out", tdo_bits, 32'b110);
        chk("undef_user_shift", us_bits, 32'd0);

        // USER chain gating and pass-through
        load_ir(5'b01000, ir_bits);
        #1;
        chk("instr_user", 32'(instr), 32'h08);
        dr_capture = 1'b1;
        #1;
        chk("user_cap", 32'(user_capture), 32'd1);
        chk("user_cap_tdo", 32'(TDO), 32'd0);
        @(negedge TCK);
        idle();
        for (int i = 0; i < 4; i++) begin
            dr_shift = 1'b1;
            user_tdo = ~i[0];
            #1;
            chk("user_shift", 32'(user_shift), 32'd1);
            chk("user_tdo_pass", 32'(TDO), (i % 2 == 0) ? 32'd1 : 32'd0);
            @(negedge TCK);
        end
        idle();
        user_tdo  = 1'b0;
        dr_update = 1'b1;
        #1;
        chk("user_update", 32'(user_update), 32'd1);
        @(negedge TCK);
        idle();
        test_reset = 1'b1;
        ir_update  = 1'b1;
        #1;
        @(negedge TCK);
        idle();
        dr_shift = 1'b1;
        #1;
        chk("test_reset_instr", 32'(instr), 32'h01);
        chk("test_reset_user", 32'(user_shift), 32'd0);
        @(negedge TCK);
        idle();

        // TRST during the 10th IDCODE shift aborts it
        dr_capture = 1'b1;
        #1;
        @(negedge TCK);
        idle();
        shift_dr(9, 32'h0, tdo_bits, us_bits);
        chk("id_first9", tdo_bits, 32'h001);
        dr_shift = 1'b1;
        TRST     = 1'b1;
        #1;
        chk("id_bit9", 32'(TDO), 32'd0);
        @(negedge TCK);
        idle();
        TRST = 1'b0;
        #1;
        chk("trst_tdo", 32'(TDO), 32'd0);
        chk("trst_tdo_en", 32'(tdo_en), 32'd0);
        chk("trst_instr", 32'(instr), 32'h01);
        shift_dr(4, 32'h0, tdo_bits, us_bits);
        chk("trst_id_reload", tdo_bits, 32'b0001);
        dr_capture = 1'b1;
        #1;
        @(negedge TCK);
        idle();
        shift_dr(32, 32'h0, tdo_bits, us_bits);
        chk("idcode_restart", tdo_bits, 32'h1000_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
